serdes_param: RTL and testbench
===============================

Name: serdes_param

Overview:
Parametrised single-clock serial-to-parallel-to-serial datapath, and the successor to the fixed 8-bit SIPO->PISO pair.
- Deserializer assembles LANES-bit beats into DATA_W-bit words. Each word also appears on a parallel tap.
- Words are buffered in a FIFO_DEPTH-entry FIFO.
- The serializer re-emits words as LANES-bit beats, with valid/ready on both sides.
- Used as the configurable lane adapter and word-buffer stage in link datapaths.

Parameters:
DATA_W, 8, word width; must be a multiple of LANES.
LANES, 1, bits per serial beat; BEATS = DATA_W/LANES, and BEATS must be >= 1.
FIFO_DEPTH, 4, word FIFO entries; power of 2 and >= 2.
MSB_FIRST, 0, 0 = least-significant beat first, 1 = most-significant beat first; applies to both directions.

Ports:
pclk_i  in  1  single clock; all logic on rising edge.
rst_i  in  1  synchronous reset, active-high.
flush_i  in  1  synchronous clear of all datapath state; config is unaffected.
s_data_i  in  LANES  serial input beat.
s_valid_i  in  1  input beat valid.
s_ready_o  out  1  input beat accepted when s_valid_i & s_ready_o.
p_data_o  out  DATA_W  assembled word tap.
p_valid_o  out  1  one-cycle pulse; p_data_o valid.
m_data_o  out  LANES  serial output beat.
m_valid_o  out  1  output beat valid.
m_ready_i  in  1  downstream accepts beat.
m_sof_o  out  1  high with m_valid_o on the first beat of each word.

Behaviour:
- Reset (rst_i high at an edge):
  - Clears rx_cnt, the FIFO pointers, the serializer FSM (to IDLE) and tx_cnt.
  - p_data_o=0, p_valid_o=0, m_valid_o=0, m_data_o=0, m_sof_o=0.
  - s_ready_o is forced 0 while rst_i is high and is 1 on the first cycle after reset.
- Beat placement, beat k (0..BEATS-1):
  - MSB_FIRST=0: bits [k*LANES +: LANES].
  - MSB_FIRST=1: bits [DATA_W-1-k*LANES -: LANES].
- Deserializer:
  - rx_cnt increments on each accepted beat.
  - On acceptance of beat BEATS-1, the complete word (including the current beat) is pushed to the FIFO at that edge and rx_cnt wraps to 0.
  - p_data_o/p_valid_o are registered: the pulse appears the cycle after the push.
- s_ready_o = (rx_cnt != BEATS-1) | !fifo_full. This has no combinational path from m_ready_i.
  - Non-final beats are always accepted.
  - The final beat stalls while the FIFO is full.
- Serializer FSM:
  - IDLE: if the FIFO is non-empty, pop into the shift register, tx_cnt=0, go to SHIFT.
  - SHIFT: m_valid_o=1, m_data_o = beat tx_cnt, m_sof_o=(tx_cnt==0).
    - On m_ready_i, tx_cnt increments.
    - On acceptance of the last beat: if the FIFO is non-empty, pop and reload in the same edge (no bubble, stay in SHIFT); else go to IDLE.
- Hold rule: m_data_o and m_sof_o stay stable while m_valid_o & !m_ready_i. m_valid_o never drops without acceptance, except on reset or flush.
- Latency: final input beat accepted at edge t -> m_valid_o high in the cycle after edge t+1. Steady-state throughput is 1 beat/cycle each side.
- Capacity: FIFO_DEPTH words in the FIFO, plus 1 in the serializer, plus one partial word in the deserializer.
- FIFO rules:
  - Push occurs only when not full.
  - Pop occurs only when not empty.
  - Simultaneous push and pop is legal; the level is unchanged.
  - Pointers are log2(FIFO_DEPTH)+1 bits and wrap naturally; full/empty are taken from MSB/address comparison.
- flush_i has the same effect as reset on datapath state:
  - Drops any partial word and the FIFO contents.
  - Aborts any word in flight: m_valid_o=0 in the next cycle.
  - s_ready_o stays 1 during flush; beats offered during flush are discarded.
- Reset and flush are both valid mid-word; there is no residual output afterwards.

Optional Feature:
SERDES_PARAM_STATUS_EN
- Defined: adds output fifo_level_o [log2(FIFO_DEPTH)+1] (current FIFO occupancy) and output word_cnt_o [16], a wrapping count of words fully transmitted (last beat accepted). Both are cleared by reset and by flush.
- Undefined: neither port exists and there is no counter logic.

Decomposition:
- Package serdes_pkg:
  - Serializer state enum (IDLE, SHIFT).
  - Local clog2 function.
  - Constants BEATS_W and PTR_W derived from the parameters.
- Sub-module serdes_fifo_sync: single-clock FIFO parametrised by width and depth, with push/pop/full/empty/level and synchronous clear. It carries all FIFO boundary logic.

Test Plan:
- DATA_W=8, LANES=1, MSB_FIRST=0: input beats 1,0,1,0,0,1,0,1 back-to-back -> p_valid_o pulse with p_data_o=0xA5; m_valid_o rises 2 cycles after the last accept; output beats are identical and m_sof_o is high on the first beat only.
- LANES=2, MSB_FIRST=1: beats 2'b10,2'b10,2'b01,2'b01 -> p_data_o=0xA5; output beats are in the same order.
- FIFO_DEPTH=4, m_ready_i=0: stream 6 words -> words 1-5 are absorbed; s_ready_o drops at the final beat of word 6; after releasing m_ready_i, all 6 words emerge in order with no gap between words.
- m_ready_i toggling 50%: m_data_o and m_sof_o are held stable on every stalled cycle; the output word sequence 0x00..0x0F is lossless.
- Flush after 3 beats of a word while the serializer is mid-word -> m_valid_o=0 in the next cycle; FIFO empty; the next full word 0x3C is passed intact.
- Reset asserted mid-transfer -> all outputs at reset values; with SERDES_PARAM_STATUS_EN, fifo_level_o=0 and word_cnt_o=0, and word_cnt_o=3 after 3 words are transmitted.

Source files
------------

// File: rtl/serdes_pkg.sv
// Shared types and width helpers for the serdes_param lane adapter.
// Optional status outputs are enabled with the SERDES_PARAM_STATUS_EN macro.
`timescale 1ns/1ps
package serdes_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } ser_state_e;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << result) < value) result = result + 1;
    end
    return result;
  endfunction

  // Counter width that stays at least one bit when there is a single beat per word.
  function automatic int cnt_w(input int count);
    return (count <= 1) ? 1 : clog2(count);
  endfunction

  // FIFO pointers carry one extra wrap bit so full and empty can be told apart.
  function automatic int ptr_w(input int depth);
    return clog2(depth) + 1;
  endfunction

  localparam int DEF_DATA_W     = 8;
  localparam int DEF_LANES      = 1;
  localparam int DEF_FIFO_DEPTH = 4;
  localparam int BEATS_W        = cnt_w(DEF_DATA_W / DEF_LANES);
  localparam int PTR_W          = ptr_w(DEF_FIFO_DEPTH);

endpackage

// File: rtl/serdes_fifo_sync.sv
// Single-clock word FIFO with wrap-bit pointers, synchronous clear and occupancy.
// Pushes while full and pops while empty are ignored here, so callers need no guards.
`timescale 1ns/1ps
module serdes_fifo_sync
  import serdes_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_clear,
  input  logic                    i_push,
  input  logic [WIDTH-1:0]        i_push_data,
  input  logic                    i_pop,
  output logic [WIDTH-1:0]        o_pop_data,
  output logic                    o_full,
  output logic                    o_empty,
  output logic [ptr_w(DEPTH)-1:0] o_level
);

  localparam int AW = clog2(DEPTH);
  localparam int PW = ptr_w(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wptr;
  logic [PW-1:0]    r_rptr;
  logic             w_push_ok;
  logic             w_pop_ok;
  logic             w_clr;

  assign w_clr      = i_rst || i_clear;
  assign o_full     = (r_wptr[PW-1] != r_rptr[PW-1]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign o_empty    = (r_wptr == r_rptr);
  assign o_level    = r_wptr - r_rptr;
  assign w_push_ok  = i_push && !o_full;
  assign w_pop_ok   = i_pop && !o_empty;
  assign o_pop_data = r_mem[r_rptr[AW-1:0]];

  always_ff @(posedge i_clk) begin
    if (w_clr) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push_ok) r_wptr <= r_wptr + 1'b1;
      if (w_pop_ok)  r_rptr <= r_rptr + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push_ok && !w_clr) r_mem[r_wptr[AW-1:0]] <= i_push_data;
  end

endmodule

// File: rtl/serdes_param.sv
// Lane adapter: assembles serial beats into words, buffers them, re-serialises them.
// Define SERDES_PARAM_STATUS_EN to add fifo_level_o and word_cnt_o status outputs.
`timescale 1ns/1ps
module serdes_param
  import serdes_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int LANES      = 1,
  parameter int FIFO_DEPTH = 4,
  parameter int MSB_FIRST  = 0
) (
  input  logic                         pclk_i,
  input  logic                         rst_i,
  input  logic                         flush_i,
  input  logic [LANES-1:0]             s_data_i,
  input  logic                         s_valid_i,
  output logic                         s_ready_o,
  output logic [DATA_W-1:0]            p_data_o,
  output logic                         p_valid_o,
  output logic [LANES-1:0]             m_data_o,
  output logic                         m_valid_o,
  input  logic                         m_ready_i,
  output logic                         m_sof_o,
`ifdef SERDES_PARAM_STATUS_EN
  output logic [ptr_w(FIFO_DEPTH)-1:0] fifo_level_o,
  output logic [15:0]                  word_cnt_o,
`endif
  output logic                         dbg_state_o,
  output logic [ptr_w(FIFO_DEPTH)-1:0] dbg_level_o
);

  // Handshake: a beat moves on any rising edge where valid and ready are both high;
  // a producer holds valid and data stable until that edge, and ready never
  // depends combinationally on the opposite side's ready.

  localparam int BEATS = DATA_W / LANES;
  localparam int L_BW  = cnt_w(BEATS);
  localparam int L_PW  = ptr_w(FIFO_DEPTH);
  localparam logic [L_BW-1:0] LAST_BEAT = L_BW'(BEATS - 1);

  function automatic int beat_lsb(input int k);
    return (MSB_FIRST != 0) ? (DATA_W - (k + 1) * LANES) : (k * LANES);
  endfunction

  logic [L_BW-1:0]   r_rx_cnt;
  logic [DATA_W-1:0] r_rx_word;
  logic [DATA_W-1:0] r_p_data;
  logic              r_p_valid;
  logic [DATA_W-1:0] w_rx_word;
  logic              w_s_ready;
  logic              w_rx_accept;
  logic              w_push;

  ser_state_e        r_state;
  ser_state_e        w_state_nxt;
  logic [L_BW-1:0]   r_tx_cnt;
  logic [DATA_W-1:0] r_shift;
  logic              w_pop;
  logic              w_tx_last;

  logic [DATA_W-1:0] w_fifo_data;
  logic              w_full;
  logic              w_empty;
  logic [L_PW-1:0]   w_level;

  serdes_fifo_sync #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk       (pclk_i),
    .i_rst       (rst_i),
    .i_clear     (flush_i),
    .i_push      (w_push),
    .i_push_data (w_rx_word),
    .i_pop       (w_pop),
    .o_pop_data  (w_fifo_data),
    .o_full      (w_full),
    .o_empty     (w_empty),
    .o_level     (w_level)
  );

  // ---------------- deserializer ----------------
  // Only the final beat of a word can stall, and only on a registered full flag.
  assign w_s_ready   = !rst_i && (flush_i || (r_rx_cnt != LAST_BEAT) || !w_full);
  assign w_rx_accept = s_valid_i && w_s_ready && !flush_i;
  assign w_push      = w_rx_accept && (r_rx_cnt == LAST_BEAT);

  always_comb begin
    w_rx_word = r_rx_word;
    w_rx_word[beat_lsb(int'(r_rx_cnt)) +: LANES] = s_data_i;
  end

  always_ff @(posedge pclk_i) begin
    if (rst_i || flush_i) begin
      r_rx_cnt  <= '0;
      r_rx_word <= '0;
      r_p_data  <= '0;
      r_p_valid <= 1'b0;
    end else begin
      r_p_valid <= w_push;
      if (w_push) r_p_data <= w_rx_word;
      if (w_rx_accept) begin
        r_rx_word <= w_rx_word;
        r_rx_cnt  <= (r_rx_cnt == LAST_BEAT) ? '0 : r_rx_cnt + 1'b1;
      end
    end
  end

  assign s_ready_o = w_s_ready;
  assign p_data_o  = r_p_data;
  assign p_valid_o = r_p_valid;

  // ---------------- serializer ----------------
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_tx_last   = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (m_ready_i && (r_tx_cnt == LAST_BEAT)) begin
          w_tx_last = 1'b1;
          // Reload in the same edge so back-to-back words leave no bubble.
          if (!w_empty) w_pop = 1'b1;
          else          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge pclk_i) begin
    if (rst_i || flush_i) begin
      r_state  <= IDLE;
      r_tx_cnt <= '0;
      r_shift  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_pop) begin
        r_shift  <= w_fifo_data;
        r_tx_cnt <= '0;
      end else if ((r_state == SHIFT) && m_ready_i) begin
        r_tx_cnt <= r_tx_cnt + 1'b1;
      end
    end
  end

  assign m_valid_o   = (r_state == SHIFT);
  assign m_data_o    = m_valid_o ? r_shift[beat_lsb(int'(r_tx_cnt)) +: LANES] : '0;
  assign m_sof_o     = m_valid_o && (r_tx_cnt == '0);
  assign dbg_state_o = r_state;
  assign dbg_level_o = w_level;

`ifdef SERDES_PARAM_STATUS_EN
  logic [15:0] r_word_cnt;

  always_ff @(posedge pclk_i) begin
    if (rst_i || flush_i) r_word_cnt <= '0;
    else if (w_tx_last)   r_word_cnt <= r_word_cnt + 16'd1;
  end

  assign fifo_level_o = w_level;
  assign word_cnt_o   = r_word_cnt;
`endif

endmodule

// File: tb/tb_serdes_param.sv
// Self-checking bench for serdes_param: an 8x1 LSB-first instance and an 8x2 MSB-first instance.
// Build with SERDES_PARAM_STATUS_EN defined to also check the status outputs.
`timescale 1ns/1ps
module tb_serdes_param;

  // ---------------- clock / reset / signals ----------------
  logic       clk;
  logic       rst;
  logic       flush;
  logic [0:0] s_data;
  logic       s_valid;
  logic       s_ready;
  logic [7:0] p_data;
  logic       p_valid;
  logic [0:0] m_data;
  logic       m_valid;
  logic       m_ready;
  logic       m_sof;
  logic       dbg_state;
  logic [2:0] dbg_level;

  logic [1:0] s2_data;
  logic       s2_valid;
  logic       s2_ready;
  logic [7:0] p2_data;
  logic       p2_valid;
  logic [1:0] m2_data;
  logic       m2_valid;
  logic       m2_ready;
  logic       m2_sof;
  logic       dbg2_state;
  logic [2:0] dbg2_level;

`ifdef SERDES_PARAM_STATUS_EN
  logic [2:0]  fifo_level;
  logic [15:0] word_cnt;
  logic [2:0]  fifo2_level;
  logic [15:0] word2_cnt;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  serdes_param #(.DATA_W(8), .LANES(1), .FIFO_DEPTH(4), .MSB_FIRST(0)) dut (
    .pclk_i(clk), .rst_i(rst), .flush_i(flush),
    .s_data_i(s_data), .s_valid_i(s_valid), .s_ready_o(s_ready),
    .p_data_o(p_data), .p_valid_o(p_valid),
    .m_data_o(m_data), .m_valid_o(m_valid), .m_ready_i(m_ready), .m_sof_o(m_sof),
`ifdef SERDES_PARAM_STATUS_EN
    .fifo_level_o(fifo_level), .word_cnt_o(word_cnt),
`endif
    .dbg_state_o(dbg_state), .dbg_level_o(dbg_level)
  );

  serdes_param #(.DATA_W(8), .LANES(2), .FIFO_DEPTH(4), .MSB_FIRST(1)) dut2 (
    .pclk_i(clk), .rst_i(rst), .flush_i(flush),
    .s_data_i(s2_data), .s_valid_i(s2_valid), .s_ready_o(s2_ready),
    .p_data_o(p2_data), .p_valid_o(p2_valid),
    .m_data_o(m2_data), .m_valid_o(m2_valid), .m_ready_i(m2_ready), .m_sof_o(m2_sof),
`ifdef SERDES_PARAM_STATUS_EN
    .fifo_level_o(fifo2_level), .word_cnt_o(word2_cnt),
`endif
    .dbg_state_o(dbg2_state), .dbg_level_o(dbg2_level)
  );

  // ---------------- scoreboard ----------------
  int         n_cmp;
  int         n_fail;
  int         stall_cycles;
  logic [7:0] exp_q[$];

  bit         mon_en;
  int         mon_k;
  logic [7:0] mon_word;
  bit         hold_pend;
  logic [0:0] hold_data;
  logic       hold_sof;

  task automatic mon_clear();
    mon_k     = 0;
    hold_pend = 1'b0;
    mon_word  = '0;
  endtask

  // Reference: words leave in the order they entered, beat k of a word is bit k
  // (one lane, least-significant beat first), the first beat carries sof, and a
  // stalled beat must not change or disappear.
  always @(negedge clk) begin
    logic [7:0] exp_w;
    if (mon_en) begin
      if (hold_pend) begin
        n_cmp++;
        if (m_valid !== 1'b1 || m_data !== hold_data || m_sof !== hold_sof) begin
          n_fail++;
          $display("FAIL hold: valid=%b data=%b sof=%b, required valid=1 data=%b sof=%b",
                   m_valid, m_data, m_sof, hold_data, hold_sof);
        end
      end
      hold_pend = (m_valid === 1'b1) && (m_ready === 1'b0);
      hold_data = m_data;
      hold_sof  = m_sof;
      if (m_valid === 1'b1 && m_ready === 1'b1) begin
        n_cmp++;
        if (m_sof !== (mon_k == 0)) begin
          n_fail++;
          $display("FAIL sof: beat %0d sof=%b, required %b", mon_k, m_sof, (mon_k == 0));
        end
        mon_word[mon_k] = m_data[0];
        mon_k++;
        if (mon_k == 8) begin
          mon_k = 0;
          n_cmp++;
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL out_word: got %02h, required no word", mon_word);
          end else begin
            exp_w = exp_q.pop_front();
            if (mon_word !== exp_w) begin
              n_fail++;
              $display("FAIL out_word: got %02h, required %02h", mon_word, exp_w);
            end
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive_beat(input logic d);
    int t;
    t = 0;
    s_valid = 1'b1;
    s_data  = d;
    @(negedge clk);
    while (s_ready !== 1'b1 && t < 300) begin
      t++;
      @(negedge clk);
    end
    stall_cycles += t;
    if (t >= 300) begin
      n_cmp++;
      n_fail++;
      $display("FAIL accept_timeout: s_ready=%b after %0d cycles, required 1", s_ready, t);
    end
    @(posedge clk);
    #1;
    s_valid = 1'b0;
  endtask

  task automatic send_word(input logic [7:0] w, input int max_gap);
    exp_q.push_back(w);
    for (int k = 0; k < 8; k++) begin
      if (max_gap > 0) begin
        repeat ($urandom_range(0, max_gap)) begin
          @(posedge clk);
          #1;
        end
      end
      drive_beat(w[k]);
    end
  endtask

  task automatic wait_drain(input int budget);
    int t;
    t = 0;
    while ((exp_q.size() != 0 || m_valid === 1'b1) && t < budget) begin
      @(negedge clk);
      t++;
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d words outstanding after %0d cycles, required 0", exp_q.size(), t);
    end
    @(posedge clk);
    #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst    = 1'b1;
    mon_en = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (s_ready !== 1'b0) begin
      n_fail++; $display("FAIL rst_s_ready: got %b, required 0", s_ready);
    end
    n_cmp++;
    if ({m_valid, m_sof, p_valid} !== 3'b000) begin
      n_fail++; $display("FAIL rst_flags: valid/sof/pvalid=%b, required 000", {m_valid, m_sof, p_valid});
    end
    n_cmp++;
    if (m_data !== 1'b0 || p_data !== 8'h00) begin
      n_fail++; $display("FAIL rst_data: m_data=%b p_data=%02h, required 0/00", m_data, p_data);
    end
`ifdef SERDES_PARAM_STATUS_EN
    n_cmp++;
    if (fifo_level !== 3'd0 || word_cnt !== 16'd0) begin
      n_fail++; $display("FAIL rst_status: level=%0d cnt=%0d, required 0/0", fifo_level, word_cnt);
    end
`endif
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (s_ready !== 1'b1) begin
      n_fail++; $display("FAIL post_rst_ready: got %b, required 1", s_ready);
    end
    mon_clear();
    mon_en = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    bit         bits[8] = '{1, 0, 1, 0, 0, 1, 0, 1};
    logic [7:0] w;
    for (int k = 0; k < 8; k++) w[k] = bits[k];
    m_ready = 1'b1;
    send_word(w, 0);
    @(negedge clk);
    n_cmp++;
    if (p_valid !== 1'b1 || p_data !== w) begin
      n_fail++; $display("FAIL basic_tap: p_valid=%b p_data=%02h, required 1/%02h", p_valid, p_data, w);
    end
    n_cmp++;
    if (m_valid !== 1'b0) begin
      n_fail++; $display("FAIL basic_early: m_valid=%b one cycle after accept, required 0", m_valid);
    end
    @(negedge clk);
    n_cmp++;
    if (m_valid !== 1'b1 || m_sof !== 1'b1 || p_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_latency: m_valid=%b m_sof=%b p_valid=%b, required 1/1/0", m_valid, m_sof, p_valid);
    end
    @(posedge clk);
    #1;
    wait_drain(100);
  endtask

  task automatic test_lanes2();
    logic [1:0] beats[4] = '{2'b10, 2'b10, 2'b01, 2'b01};
    logic [7:0] w;
    int         idx;
    int         t;
    w = {beats[0], beats[1], beats[2], beats[3]};
    m2_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      s2_valid = 1'b1;
      s2_data  = beats[k];
      @(negedge clk);
      n_cmp++;
      if (s2_ready !== 1'b1) begin
        n_fail++; $display("FAIL l2_ready: beat %0d s_ready=%b, required 1", k, s2_ready);
      end
      @(posedge clk);
      #1;
    end
    s2_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (p2_valid !== 1'b1 || p2_data !== w) begin
      n_fail++; $display("FAIL l2_tap: p_valid=%b p_data=%02h, required 1/%02h", p2_valid, p2_data, w);
    end
    idx = 0;
    t   = 0;
    while (idx < 4 && t < 20) begin
      @(negedge clk);
      t++;
      if (m2_valid === 1'b1) begin
        n_cmp++;
        if (m2_data !== beats[idx] || m2_sof !== (idx == 0)) begin
          n_fail++;
          $display("FAIL l2_beat: beat %0d data=%b sof=%b, required %b/%b", idx, m2_data, m2_sof, beats[idx], (idx == 0));
        end
        idx++;
      end
    end
    n_cmp++;
    if (idx != 4) begin
      n_fail++; $display("FAIL l2_count: got %0d beats, required 4", idx);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_fill();
    logic [7:0] w6;
    int         gaps;
    m_ready      = 1'b0;
    stall_cycles = 0;
    for (int i = 0; i < 5; i++) send_word(8'($urandom), 0);
    w6 = 8'($urandom);
    exp_q.push_back(w6);
    for (int k = 0; k < 7; k++) drive_beat(w6[k]);
    n_cmp++;
    if (stall_cycles != 0) begin
      n_fail++; $display("FAIL fill_absorb: %0d stall cycles, required 0", stall_cycles);
    end
`ifdef SERDES_PARAM_STATUS_EN
    n_cmp++;
    if (fifo_level !== 3'd4) begin
      n_fail++; $display("FAIL fill_level: got %0d, required 4", fifo_level);
    end
`endif
    gaps = 0;
    fork
      drive_beat(w6[7]);
      begin
        for (int i = 0; i < 3; i++) begin
          @(negedge clk);
          n_cmp++;
          if (s_ready !== 1'b0) begin
            n_fail++; $display("FAIL fill_stall: s_ready=%b on final beat, required 0", s_ready);
          end
        end
        @(posedge clk);
        #1;
        m_ready = 1'b1;
        for (int i = 0; i < 48; i++) begin
          @(negedge clk);
          if (m_valid !== 1'b1) gaps++;
        end
        n_cmp++;
        if (gaps != 0) begin
          n_fail++; $display("FAIL fill_gapless: %0d idle cycles in 48, required 0", gaps);
        end
      end
    join
    @(posedge clk);
    #1;
    wait_drain(200);
  endtask

  task automatic test_toggle(input int first, input int count, input int max_gap);
    bit done;
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < count; i++) begin
          if (first >= 0) send_word(8'(first + i), max_gap);
          else            send_word(8'($urandom), max_gap);
        end
        wait_drain(3000);
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1;
          m_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    m_ready = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_flush();
    logic [7:0] x;
    logic [7:0] y;
    int         seen;
    x       = 8'($urandom);
    y       = 8'($urandom);
    m_ready = 1'b1;
    send_word(x, 0);
    for (int k = 0; k < 3; k++) drive_beat(y[k]);
    mon_en  = 1'b0;
    flush   = 1'b1;
    s_valid = 1'b1;
    s_data  = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (s_ready !== 1'b1) begin
      n_fail++; $display("FAIL flush_ready: got %b, required 1", s_ready);
    end
    @(posedge clk);
    #1;
    flush   = 1'b0;
    s_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (m_valid !== 1'b0 || p_valid !== 1'b0) begin
      n_fail++; $display("FAIL flush_abort: m_valid=%b p_valid=%b, required 0/0", m_valid, p_valid);
    end
`ifdef SERDES_PARAM_STATUS_EN
    n_cmp++;
    if (fifo_level !== 3'd0 || word_cnt !== 16'd0) begin
      n_fail++; $display("FAIL flush_status: level=%0d cnt=%0d, required 0/0", fifo_level, word_cnt);
    end
`endif
    exp_q.delete();
    mon_clear();
    mon_en = 1'b1;
    seen   = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (m_valid === 1'b1) seen++;
    end
    n_cmp++;
    if (seen != 0) begin
      n_fail++; $display("FAIL flush_empty: %0d residual valid cycles, required 0", seen);
    end
    @(posedge clk);
    #1;
    send_word(8'h3C, 0);
    wait_drain(100);
  endtask

  task automatic test_reset_mid();
    logic [7:0] y;
    y       = 8'($urandom);
    m_ready = 1'b1;
    send_word(8'($urandom), 0);
    for (int k = 0; k < 2; k++) drive_beat(y[k]);
    mon_en = 1'b0;
    rst    = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    n_cmp++;
    if ({s_ready, m_valid, m_sof, p_valid, m_data} !== 5'b00000 || p_data !== 8'h00) begin
      n_fail++;
      $display("FAIL midrst_outputs: ready/valid/sof/pvalid/mdata=%b p_data=%02h, required 00000/00",
               {s_ready, m_valid, m_sof, p_valid, m_data}, p_data);
    end
`ifdef SERDES_PARAM_STATUS_EN
    n_cmp++;
    if (fifo_level !== 3'd0 || word_cnt !== 16'd0) begin
      n_fail++; $display("FAIL midrst_status: level=%0d cnt=%0d, required 0/0", fifo_level, word_cnt);
    end
`endif
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (s_ready !== 1'b1 || m_valid !== 1'b0) begin
      n_fail++; $display("FAIL midrst_release: s_ready=%b m_valid=%b, required 1/0", s_ready, m_valid);
    end
    exp_q.delete();
    mon_clear();
    mon_en = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) send_word(8'($urandom), 0);
    wait_drain(200);
`ifdef SERDES_PARAM_STATUS_EN
    n_cmp++;
    if (word_cnt !== 16'd3) begin
      n_fail++; $display("FAIL word_cnt: got %0d, required 3", word_cnt);
    end
`endif
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    n_cmp        = 0;
    n_fail       = 0;
    stall_cycles = 0;
    rst          = 1'b1;
    flush        = 1'b0;
    s_valid      = 1'b0;
    s_data       = '0;
    m_ready      = 1'b1;
    s2_valid     = 1'b0;
    s2_data      = '0;
    m2_ready     = 1'b1;
    mon_en       = 1'b0;
    mon_clear();

    test_reset();
    test_basic();
    test_lanes2();
    test_fill();
    test_toggle(0, 16, 0);
    test_toggle(-1, 12, 2);
    test_flush();
    test_reset_mid();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
